// File: rtl/axis_uart_rx_deframer.sv
// axis_uart_rx_deframer
// Consumes the UART receiver byte stream and finds frames of the form
// SYNC_BYTE, L, payload[L], checksum. The checksum is the 8-bit sum of L and
// all payload bytes. The payload is streamed out on a registered AXIS master.
// SOF is marked on tuser and EOF on tlast. Frame status is reported as
// single-cycle pulses on frame_ok / frame_err.
// Optional feature macro: AXIS_UART_DEFRAMER_TIMEOUT_EN. When it is defined,
// an inter-byte timeout of TIMEOUT_CYCLES aborts a stalled frame. When it is
// undefined, a partially received frame waits indefinitely.

module axis_uart_rx_deframer #(
  parameter int          AXI_DATA_WIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          MAX_LEN        = 255,
  parameter int          TIMEOUT_CYCLES = 100_000
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [1:0]                rx_error,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  output logic                      frame_ok,
  output logic [1:0]                frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  localparam logic [8:0] MAX_LEN_C   = 9'(MAX_LEN);
  localparam logic [1:0] ERR_NONE_C  = 2'b00;
  localparam logic [1:0] ERR_CSUM_C  = 2'b01;
  localparam logic [1:0] ERR_LEN_C   = 2'b10;
  localparam logic [1:0] ERR_LINE_C  = 2'b11;

  state_t     state_r, state_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic [7:0] sum_r, sum_nxt_s;
  logic       first_r, first_nxt_s;
  logic       frame_ok_r, frame_ok_nxt_s;
  logic [1:0] frame_err_r, frame_err_nxt_s;

  logic [7:0] m_tdata_r;
  logic       m_tvalid_r;
  logic       m_tlast_r;
  logic       m_tuser_r;

  logic       tready_s;
  logic       accept_s;
  logic       line_err_s;
  logic       load_s;
  logic       load_last_s;
  logic       load_user_s;
  logic       timeout_s;

  // Input ready: always open outside PAYLOAD; in PAYLOAD only when the output register can take a beat.
  always_comb begin
    tready_s = 1'b1;
    if (state_r == ST_PAYLOAD) begin
      tready_s = !m_tvalid_r || m_axis_tready;
    end else begin
      tready_s = 1'b1;
    end
  end

  assign accept_s   = s_axis_tvalid && tready_s;
  assign line_err_s = (rx_error != 2'b00);

`ifdef AXIS_UART_DEFRAMER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST_C = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_r;
  logic        to_frozen_s;

  // Downstream backpressure in PAYLOAD must not be mistaken for a silent line.
  assign to_frozen_s = (state_r == ST_PAYLOAD) && !tready_s;
  assign timeout_s   = (state_r != ST_IDLE) && !accept_s && !to_frozen_s &&
                       (to_cnt_r == TO_LAST_C);

  // Inter-byte timer: runs inside a frame, restarts on every accepted byte.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_cnt_r <= 32'd0;
    end else if ((state_r == ST_IDLE) || accept_s || timeout_s) begin
      to_cnt_r <= 32'd0;
    end else if (to_frozen_s) begin
      to_cnt_r <= to_cnt_r;
    end else begin
      to_cnt_r <= to_cnt_r + 32'd1;
    end
  end
`else
  logic [31:0] unused_timeout_cycles_s;
  assign unused_timeout_cycles_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s               = 1'b0;
`endif

  // Frame parser: next state, length/checksum bookkeeping and status pulse codes.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    sum_nxt_s       = sum_r;
    first_nxt_s     = first_r;
    frame_ok_nxt_s  = 1'b0;
    frame_err_nxt_s = ERR_NONE_C;
    load_s          = 1'b0;
    load_last_s     = 1'b0;
    load_user_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Line-errored bytes and non-sync bytes are dropped without a pulse.
        if (accept_s && !line_err_s && (s_axis_tdata == SYNC_BYTE)) begin
          state_nxt_s = ST_LEN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          if (line_err_s) begin
            frame_err_nxt_s = ERR_LINE_C;
            state_nxt_s     = ST_IDLE;
          end else if ((s_axis_tdata == 8'd0) || ({1'b0, s_axis_tdata} > MAX_LEN_C)) begin
            frame_err_nxt_s = ERR_LEN_C;
            state_nxt_s     = ST_IDLE;
          end else begin
            cnt_nxt_s   = s_axis_tdata;
            sum_nxt_s   = s_axis_tdata;
            first_nxt_s = 1'b1;
            state_nxt_s = ST_PAYLOAD;
          end
        end else if (timeout_s) begin
          frame_err_nxt_s = ERR_LINE_C;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          if (line_err_s) begin
            frame_err_nxt_s = ERR_LINE_C;
            state_nxt_s     = ST_IDLE;
          end else begin
            load_s      = 1'b1;
            load_user_s = first_r;
            load_last_s = (cnt_r == 8'd1);
            first_nxt_s = 1'b0;
            sum_nxt_s   = sum_r + s_axis_tdata;
            cnt_nxt_s   = cnt_r - 8'd1;
            if (cnt_r == 8'd1) begin
              state_nxt_s = ST_CSUM;
            end else begin
              state_nxt_s = ST_PAYLOAD;
            end
          end
        end else if (timeout_s) begin
          frame_err_nxt_s = ERR_LINE_C;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          state_nxt_s = ST_IDLE;
          if (line_err_s) begin
            frame_err_nxt_s = ERR_LINE_C;
          end else if (s_axis_tdata == sum_r) begin
            frame_ok_nxt_s = 1'b1;
          end else begin
            frame_err_nxt_s = ERR_CSUM_C;
          end
        end else if (timeout_s) begin
          frame_err_nxt_s = ERR_LINE_C;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_CSUM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Parser state, counters and registered status pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      sum_r       <= 8'd0;
      first_r     <= 1'b0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= ERR_NONE_C;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sum_r       <= sum_nxt_s;
      first_r     <= first_nxt_s;
      frame_ok_r  <= frame_ok_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

  // Output beat register: a new beat may load while the old one drains; data holds while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata_r  <= 8'd0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tuser_r  <= 1'b0;
    end else if (load_s) begin
      m_tdata_r  <= s_axis_tdata;
      m_tvalid_r <= 1'b1;
      m_tlast_r  <= load_last_s;
      m_tuser_r  <= load_user_s;
    end else if (m_axis_tready) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

  assign s_axis_tready = tready_s;
  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tlast  = m_tlast_r;
  assign m_axis_tuser  = m_tuser_r;
  assign frame_ok      = frame_ok_r;
  assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_axis_uart_rx_deframer.sv
// Directed bench for axis_uart_rx_deframer with MAX_LEN=16 and TIMEOUT_CYCLES=50.
// Expected payload beats and status pulses are queued as stimulus is driven.
// A monitor pops and compares them when the DUT produces them.
// The timeout expectation follows AXIS_UART_DEFRAMER_TIMEOUT_EN.

module tb_axis_uart_rx_deframer;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] s_axis_tdata = 8'd0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [1:0] rx_error = 2'b00;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       frame_ok;
  logic [1:0] frame_err;

  int errors = 0;
  int checks = 0;

  // Expected beats as {tuser, tlast, tdata}; expected status as {ok, err}.
  logic [9:0] beat_q[$];
  logic [2:0] stat_q[$];

  logic       stall_seen = 1'b0;
  logic [9:0] held_beat = 10'd0;

  axis_uart_rx_deframer #(
    .AXI_DATA_WIDTH(8),
    .SYNC_BYTE(8'hA5),
    .MAX_LEN(16),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .rx_error(rx_error),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .frame_ok(frame_ok),
    .frame_err(frame_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one byte and hold it until the DUT accepts it (bounded).
  task automatic send_byte(input logic [7:0] d, input logic [1:0] e);
    bit done;
    done = 1'b0;
    s_axis_tdata  = d;
    rx_error      = e;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge aclk);
      if (s_axis_tready) done = 1'b1;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    rx_error      = 2'b00;
    check("send_handshake", {31'd0, done}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b[]);
    foreach (b[i]) send_byte(b[i], 2'b00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitor: compares handshaked beats, stall stability and status pulses.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (stall_seen) check("hold_stable", {22'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'd0, held_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", {24'd0, m_axis_tdata}, 32'hFFFF_FFFF);
        end else begin
          check("beat", {22'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'd0, beat_q.pop_front()});
        end
      end
      stall_seen = m_axis_tvalid && !m_axis_tready;
      held_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (frame_ok || (frame_err != 2'b00)) begin
        check("ok_err_exclusive", {31'd0, frame_ok && (frame_err != 2'b00)}, 32'd0);
        if (stat_q.size() == 0) begin
          check("unexpected_status", {29'd0, frame_ok, frame_err}, 32'hFFFF_FFFF);
        end else begin
          check("status", {29'd0, frame_ok, frame_err}, {29'd0, stat_q.pop_front()});
        end
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    // Reset values
    idle(3);
    @(negedge aclk);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_tlast_tuser", {30'd0, m_axis_tlast, m_axis_tuser}, 32'd0);
    check("rst_status", {29'd0, frame_ok, frame_err}, 32'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    idle(2);

    // Good frame: checksum 03+11+22+33 = 69
    beat_q.push_back({1'b1, 1'b0, 8'h11});
    beat_q.push_back({1'b0, 1'b0, 8'h22});
    beat_q.push_back({1'b0, 1'b1, 8'h33});
    stat_q.push_back({1'b1, 2'b00});
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    idle(3);

    // Bad checksum: payload still delivered, checksum error pulse
    beat_q.push_back({1'b1, 1'b0, 8'h11});
    beat_q.push_back({1'b0, 1'b0, 8'h22});
    beat_q.push_back({1'b0, 1'b1, 8'h33});
    stat_q.push_back({1'b0, 2'b01});
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A});
    idle(3);

    // Length errors: zero and above MAX_LEN
    stat_q.push_back({1'b0, 2'b10});
    send_frame('{8'hA5, 8'h00});
    idle(2);
    stat_q.push_back({1'b0, 2'b10});
    send_frame('{8'hA5, 8'hFF});
    idle(2);

    // Leading junk dropped; output stall; checksum 02+01+02 = 05
    beat_q.push_back({1'b1, 1'b0, 8'h01});
    beat_q.push_back({1'b0, 1'b1, 8'h02});
    stat_q.push_back({1'b1, 2'b00});
    send_frame('{8'h00, 8'h7E, 8'hA5, 8'h02});
    m_axis_tready = 1'b0;
    send_byte(8'h01, 2'b00);
    s_axis_tdata  = 8'h02;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check("stall_s_tready", {31'd0, s_axis_tready}, 32'd0);
      check("stall_m_beat", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'h01});
    end
    @(posedge aclk);
    #1 m_axis_tready = 1'b1;
    send_byte(8'h02, 2'b00);
    send_byte(8'h05, 2'b00);
    idle(3);

    // Line error mid-payload, then a recovered one-byte frame
    beat_q.push_back({1'b1, 1'b0, 8'h10});
    stat_q.push_back({1'b0, 2'b11});
    send_frame('{8'hA5, 8'h04, 8'h10});
    send_byte(8'h20, 2'b01);
    idle(2);
    beat_q.push_back({1'b1, 1'b1, 8'h07});
    stat_q.push_back({1'b1, 2'b00});
    send_frame('{8'hA5, 8'h01, 8'h07, 8'h08});
    idle(3);

    // Stalled frame: timeout pulse only when the feature is built in
    beat_q.push_back({1'b1, 1'b0, 8'hAA});
`ifdef AXIS_UART_DEFRAMER_TIMEOUT_EN
    stat_q.push_back({1'b0, 2'b11});
`endif
    send_frame('{8'hA5, 8'h02, 8'hAA});
    idle(60);
    check("timeout_status_drained", stat_q.size(), 32'd0);

    // Reset mid-frame: pending beat lost, no pulse, parser back in IDLE
    @(negedge aclk);
    aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
    idle(1);
    m_axis_tready = 1'b0;
    send_frame('{8'hA5, 8'h02, 8'hBB});
    @(negedge aclk);
    check("pre_reset_m_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    aresetn = 1'b0;
    #1;
    check("midrst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("midrst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check("midrst_status", {29'd0, frame_ok, frame_err}, 32'd0);
    idle(2);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    idle(1);

    // Fresh frame after reset proves the parser restarted in IDLE
    beat_q.push_back({1'b1, 1'b1, 8'h55});
    stat_q.push_back({1'b1, 2'b00});
    send_frame('{8'hA5, 8'h01, 8'h55, 8'h56});
    idle(5);

    check("beats_drained", beat_q.size(), 32'd0);
    check("status_drained", stat_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
